// File: rtl/matmult_operand_mem_pkg.sv
// rtl/matmult_operand_mem_pkg.sv - shared widths, FSM encoding and load/run constants
package matmult_operand_mem_pkg;

   localparam int DATA_W     = 8;
   localparam int DIM        = 16;
   localparam int ADDR_W     = 4;
   localparam int RUN_CYCLES = 20;
   localparam int LOAD_COUNT = 512;
   localparam int LOAD_W     = $clog2(LOAD_COUNT);
   localparam int RUN_W      = $clog2(RUN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_START,
      S_RUN
   } state_t;

endpackage

// File: rtl/matmult_operand_mem_operand_bank.sv
// rtl/matmult_operand_mem_operand_bank.sv - 16x16 element register file, one-element write, 16-wide registered read
module operand_bank
   import matmult_operand_mem_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wr_row,
   input  logic [ADDR_W-1:0]          wr_lane,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       re,
   input  logic [ADDR_W-1:0]          rd_row,
   output logic [DIM-1:0][DATA_W-1:0] rd_data
);

   // Storage is deliberately not reset; only the read register is.
   logic [DIM-1:0][DATA_W-1:0] mem [DIM];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_row][wr_lane] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (re) begin
         rd_data <= mem[rd_row];
      end
   end

endmodule

// File: rtl/matmult_operand_mem.sv
// rtl/matmult_operand_mem.sv - operand loader/responder for the 16x16 matmult kernel
// Optional MATMULT_AUTO_START_EN: start automatically once loaded instead of waiting for Go.
module matmult_operand_mem
   import matmult_operand_mem_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Ld_valid,
   output logic              Ld_ready,
   input  logic [DATA_W-1:0] Ld_data,
   input  logic              Go,
   output logic              Start,
   output logic              Busy,
   input  logic              Rd_en,
   input  logic [ADDR_W-1:0] Rd_A_addr,
   input  logic [ADDR_W-1:0] Rd_B_addr,
   output logic [DATA_W-1:0] A_0,  A_1,  A_2,  A_3,  A_4,  A_5,  A_6,  A_7,
   output logic [DATA_W-1:0] A_8,  A_9,  A_10, A_11, A_12, A_13, A_14, A_15,
   output logic [DATA_W-1:0] B_0,  B_1,  B_2,  B_3,  B_4,  B_5,  B_6,  B_7,
   output logic [DATA_W-1:0] B_8,  B_9,  B_10, B_11, B_12, B_13, B_14, B_15
);

   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_COUNT - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES);

   state_t                     state, next_state;
   logic [LOAD_W-1:0]          load_cnt;
   logic [RUN_W-1:0]           run_cnt;
   logic                       hs;
   logic                       a_we, b_we;
   logic [DIM-1:0][DATA_W-1:0] a_rd, b_rd;

   assign hs = Ld_valid & Ld_ready;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= S_IDLE;
         load_cnt <= '0;
         run_cnt  <= '0;
      end else begin
         state <= next_state;
         if (hs) begin
            load_cnt <= load_cnt + 1'b1;
         end
         if (state == S_RUN) begin
            run_cnt <= run_cnt + 1'b1;
         end else begin
            run_cnt <= '0;
         end
      end
   end

   always_comb begin
      next_state = state;
      Ld_ready   = 1'b0;
      Start      = 1'b0;
      Busy       = 1'b0;
      case (state)
         S_IDLE: begin
            Ld_ready = 1'b1;
            if (Ld_valid) next_state = S_LOAD;
         end
         S_LOAD: begin
            Ld_ready = 1'b1;
            if (Ld_valid && load_cnt == LOAD_LAST) next_state = S_WAIT;
         end
         S_WAIT: begin
`ifdef MATMULT_AUTO_START_EN
            next_state = S_START;
`else
            if (Go) next_state = S_START;
`endif
         end
         S_START: begin
            Start      = 1'b1;
            next_state = S_RUN;
         end
         S_RUN: begin
            Busy = 1'b1;
            if (run_cnt == RUN_LAST) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Count bit 8 selects B; B is banked by column so one read returns a full column.
   assign a_we = hs & ~load_cnt[8];
   assign b_we = hs &  load_cnt[8];

   operand_bank u_bank_a (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .we      (a_we),
      .wr_row  (load_cnt[7:4]),
      .wr_lane (load_cnt[3:0]),
      .wr_data (Ld_data),
      .re      (Rd_en),
      .rd_row  (Rd_A_addr),
      .rd_data (a_rd)
   );

   operand_bank u_bank_b (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .we      (b_we),
      .wr_row  (load_cnt[3:0]),
      .wr_lane (load_cnt[7:4]),
      .wr_data (Ld_data),
      .re      (Rd_en),
      .rd_row  (Rd_B_addr),
      .rd_data (b_rd)
   );

   assign A_0  = a_rd[0];   assign A_1  = a_rd[1];   assign A_2  = a_rd[2];   assign A_3  = a_rd[3];
   assign A_4  = a_rd[4];   assign A_5  = a_rd[5];   assign A_6  = a_rd[6];   assign A_7  = a_rd[7];
   assign A_8  = a_rd[8];   assign A_9  = a_rd[9];   assign A_10 = a_rd[10];  assign A_11 = a_rd[11];
   assign A_12 = a_rd[12];  assign A_13 = a_rd[13];  assign A_14 = a_rd[14];  assign A_15 = a_rd[15];
   assign B_0  = b_rd[0];   assign B_1  = b_rd[1];   assign B_2  = b_rd[2];   assign B_3  = b_rd[3];
   assign B_4  = b_rd[4];   assign B_5  = b_rd[5];   assign B_6  = b_rd[6];   assign B_7  = b_rd[7];
   assign B_8  = b_rd[8];   assign B_9  = b_rd[9];   assign B_10 = b_rd[10];  assign B_11 = b_rd[11];
   assign B_12 = b_rd[12];  assign B_13 = b_rd[13];  assign B_14 = b_rd[14];  assign B_15 = b_rd[15];

endmodule

// File: tb/tb_matmult_operand_mem.sv
// tb/tb_matmult_operand_mem.sv - randomized bench with behavioural model for matmult_operand_mem
module tb_matmult_operand_mem;
   import matmult_operand_mem_pkg::*;

`ifdef MATMULT_AUTO_START_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, ld_valid, ld_ready, go, start, busy, rd_en;
   logic [7:0] ld_data;
   logic [3:0] rd_a, rd_b;
   logic [7:0] a_o [16];
   logic [7:0] b_o [16];

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   bit rand_rd = 1'b0;

   matmult_operand_mem dut (
      .Clk(clk), .Rst_n(rst_n), .Ld_valid(ld_valid), .Ld_ready(ld_ready), .Ld_data(ld_data),
      .Go(go), .Start(start), .Busy(busy), .Rd_en(rd_en), .Rd_A_addr(rd_a), .Rd_B_addr(rd_b),
      .A_0(a_o[0]),   .A_1(a_o[1]),   .A_2(a_o[2]),   .A_3(a_o[3]),
      .A_4(a_o[4]),   .A_5(a_o[5]),   .A_6(a_o[6]),   .A_7(a_o[7]),
      .A_8(a_o[8]),   .A_9(a_o[9]),   .A_10(a_o[10]), .A_11(a_o[11]),
      .A_12(a_o[12]), .A_13(a_o[13]), .A_14(a_o[14]), .A_15(a_o[15]),
      .B_0(b_o[0]),   .B_1(b_o[1]),   .B_2(b_o[2]),   .B_3(b_o[3]),
      .B_4(b_o[4]),   .B_5(b_o[5]),   .B_6(b_o[6]),   .B_7(b_o[7]),
      .B_8(b_o[8]),   .B_9(b_o[9]),   .B_10(b_o[10]), .B_11(b_o[11]),
      .B_12(b_o[12]), .B_13(b_o[13]), .B_14(b_o[14]), .B_15(b_o[15])
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [127:0] pack(input logic [7:0] v [16]);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[k*8 +: 8] = v[k];
      return r;
   endfunction

   // Behavioural model: matrices in mathematical form plus the load/run timeline.
   logic [7:0] ma [16][16];
   logic [7:0] mb [16][16];
   logic [7:0] exp_a [16];
   logic [7:0] exp_b [16];
   int  m_loaded = 0;
   int  m_run = 0;
   bit  m_start = 1'b0;
   bit  chk_en = 1'b0;
   bit  p_wait, p_start, hs;
   int  p_run, n;

   initial begin
      for (int k = 0; k < 16; k++) begin
         exp_a[k] = 8'h00;
         exp_b[k] = 8'h00;
      end
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_loaded = 0;
            m_run    = 0;
            m_start  = 1'b0;
            for (int k = 0; k < 16; k++) begin
               exp_a[k] = 8'h00;
               exp_b[k] = 8'h00;
            end
            chk_en = 1'b1;
         end else begin
            if (rd_en) begin
               for (int k = 0; k < 16; k++) begin
                  exp_a[k] = ma[rd_a][k];
                  exp_b[k] = mb[k][rd_b];
               end
            end
            hs      = ld_valid && (m_loaded < 512);
            p_wait  = (m_loaded == 512) && !m_start && (m_run == 0);
            p_start = m_start;
            p_run   = m_run;
            if (hs) begin
               n = m_loaded;
               if (n < 256) ma[n / 16][n % 16] = ld_data;
               else         mb[(n - 256) / 16][(n - 256) % 16] = ld_data;
               m_loaded++;
            end
            m_start = p_wait && (AUTO || go);
            if (p_start) begin
               m_run = RUN_CYCLES + 1;
            end else if (p_run > 0) begin
               m_run = p_run - 1;
               if (m_run == 0) m_loaded = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("ld_ready", ld_ready, m_loaded < 512);
         check("start", start, m_start);
         check("busy", busy, m_run > 0);
         check("a_row", pack(a_o), pack(exp_a));
         check("b_col", pack(b_o), pack(exp_b));
      end
   end

   initial forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && start === 1'b1) start_cnt++;
   end

   initial forever begin
      @(negedge clk);
      #1;
      if (rand_rd) begin
         rd_en = 1'($urandom_range(0, 1));
         rd_a  = 4'($urandom);
         rd_b  = 4'($urandom);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] d, input int max_gap);
      int  w = 0;
      bit  ok;
      repeat ($urandom_range(0, max_gap)) begin
         ld_valid = 1'b0;
         @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data  = d;
      do begin
         ok = ld_ready;
         @(negedge clk);
         w++;
      end while (!ok && w < 200);
      if (!ok) check("send_handshake", ok, 1);
      ld_valid = 1'b0;
   endtask

   task automatic fire();
`ifdef MATMULT_AUTO_START_EN
      int w = 0;
      while (start !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("auto_start_seen", start, 1);
`else
      repeat (3) @(negedge clk);
      check("wait_holds_ready", ld_ready, 0);
      check("wait_no_start", start, 0);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("start_after_go", start, 1);
`endif
   endtask

   task automatic run_phase(input bit lockout);
      int  r = 0;
      @(negedge clk);
      while (busy === 1'b1 && r < 1000) begin
         r++;
         ld_valid = lockout && r <= 4;
         ld_data  = 8'hFF;
         if (lockout && r <= 4) check("run_lockout_ready", ld_ready, 0);
         if (lockout && r == 5) begin
            rd_en = 1'b1; rd_a = 4'd3; rd_b = 4'd5;
         end
         if (lockout && r == 6) begin
            rd_en = 1'b0;
            for (int k = 0; k < 16; k++) check("run_reread_a", a_o[k], 8'(48 + k));
         end
         @(negedge clk);
      end
      ld_valid = 1'b0;
      check("busy_length", r, RUN_CYCLES + 1);
      check("idle_after_run", ld_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; go = 1'b0;
      rd_en = 1'b0; rd_a = 4'd0; rd_b = 4'd0;

      // Reset held for two cycles.
      repeat (2) @(negedge clk);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", ld_ready, 1);
      for (int k = 0; k < 16; k++) begin
         check("rst_a", a_o[k], 0);
         check("rst_b", b_o[k], 0);
      end
      rst_n = 1'b1;

      // A Go seen in idle must not be remembered.
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;

      // Known pattern: A[r][c] = r*16+c, B = identity, back to back.
      for (int i = 0; i < 512; i++) begin
         if (i < 256) send(8'(i), 0);
         else         send(((i - 256) / 16 == (i - 256) % 16) ? 8'd1 : 8'd0, 0);
      end
`ifdef MATMULT_AUTO_START_EN
      check("start_t1", start, 0);
      @(negedge clk);
      check("start_t2", start, 1);
`else
      check("wait_ready", ld_ready, 0);
      repeat (5) @(negedge clk);
      check("no_start_without_go", start_cnt, 0);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("start_after_go", start, 1);
`endif
      run_phase(1'b1);
      check("start_once", start_cnt, 1);

      rd_en = 1'b1; rd_a = 4'd3; rd_b = 4'd5;
      @(negedge clk);
      rd_en = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check("read_a_row3", a_o[k], 8'(48 + k));
         check("read_b_col5", b_o[k], (k == 5) ? 8'd1 : 8'd0);
      end
      for (int c = 0; c < 4; c++) begin
         rd_a = 4'($urandom); rd_b = 4'($urandom);
         @(negedge clk);
         check("hold_a3", a_o[3], 8'd51);
         check("hold_b5", b_o[5], 8'd1);
         check("hold_b0", b_o[0], 8'd0);
      end

      // Random data with backpressure gaps; 511 elements must not start.
      rand_rd = 1'b1;
      for (int i = 0; i < 511; i++) send(8'($urandom), 2);
      repeat (10) @(negedge clk);
      check("no_start_511", start_cnt, 1);
      check("ready_after_511", ld_ready, 1);
      send(8'($urandom), 2);
      check("wait_after_512", ld_ready, 0);
      fire();
      run_phase(1'b0);
      check("start_count_2", start_cnt, 2);

      // Reset mid-load, then a full reload is required.
      for (int i = 0; i < 100; i++) send(8'($urandom), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_ready", ld_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_a_zero", pack(a_o), 0);
      for (int i = 0; i < 511; i++) send(8'($urandom), 1);
      repeat (5) @(negedge clk);
      check("reload_needs_512", ld_ready, 1);
      check("reload_no_start", start_cnt, 2);
      send(8'($urandom), 1);
      fire();
      run_phase(1'b0);
      check("start_count_3", start_cnt, 3);

      rand_rd = 1'b0;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
